// File: rtl/vga_sync_porch.sv
// -----------------------------------------------------------------------------
// vga_sync_porch
//
// Output stage of the VGA video path. Takes the active-area flags produced by
// the sync generator (high while the pixel is inside the visible area) plus the
// RGB video that accompanies them. It rebuilds the column/row position from
// the frame start (rising edge of i_VSync). From that position it produces
// active-low HSync/VSync pulses with front and back porches. The video is
// aligned to those pulses and blanked outside the visible area.
//
// Ports
//   i_Clk                    system clock
//   i_Rst_L                  asynchronous active-low reset
//   i_HSync                  high while the input column is in the active area
//   i_VSync                  high while the input row is in the active area
//   i_Red/Grn/Blu_Video      input video, VIDEO_WIDTH bits per channel
//   o_HSync                  active-low horizontal sync
//   o_VSync                  active-low vertical sync
//   o_Red/Grn/Blu_Video      aligned and blanked video
//   o_Locked                 high once the first frame start has been seen
//   o_Resync                 one-cycle pulse: frame start at unexpected position
//
// Pipeline
//   input cycle t   : frame-start detection on i_VSync
//   stage p0 (t+1)  : column/row counters, lock flag, resync pulse
//   stage p1 (t+2)  : sync and video output registers
// -----------------------------------------------------------------------------
module vga_sync_porch #(
  parameter int VIDEO_WIDTH      = 3,
  parameter int TOTAL_COLS       = 800,
  parameter int TOTAL_ROWS       = 525,
  parameter int ACTIVE_COLS      = 640,
  parameter int ACTIVE_ROWS      = 480,
  parameter int FRONT_PORCH_HORZ = 18,
  parameter int BACK_PORCH_HORZ  = 50,
  parameter int FRONT_PORCH_VERT = 10,
  parameter int BACK_PORCH_VERT  = 33,
  parameter int VIDEO_LAG        = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Locked,
  output logic                   o_Resync
);

  localparam int VID_W = 3 * VIDEO_WIDTH;

  // Position limits, pre-sized to the 10-bit counters.
  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);

  // Sync pulses sit between the front porch and the back porch.
  localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [9:0] HS_LAST  = 10'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
  localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [9:0] VS_LAST  = 10'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic in_range(input logic [9:0] pos,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

  function automatic logic [VIDEO_WIDTH-1:0] blank_video(
      input logic [VIDEO_WIDTH-1:0] pix,
      input logic                   show);
    return show ? pix : '0;
  endfunction

  // The column is rebuilt from the counter, so the input column flag carries
  // no extra information here.
  logic unused_hsync_flag;
  assign unused_hsync_flag = i_HSync;

  // ---------------------------------------------------------------------------
  // Input cycle: frame-start detection
  // ---------------------------------------------------------------------------
  logic vsync_d;
  logic frame_start;

  assign frame_start = i_VSync & ~vsync_d;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= i_VSync;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: position counters, lock and resync
  // ---------------------------------------------------------------------------
  logic [9:0] col_q;
  logic [9:0] row_q;
  logic [9:0] col_d;
  logic [9:0] row_d;
  logic       locked_q;
  logic       resync_q;
  logic       at_frame_end;
  logic       resync_d;

  assign at_frame_end = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // A frame start while already locked is expected only when the counters are
  // on the last pixel of the frame; anywhere else the source has slipped.
  assign resync_d = frame_start & locked_q & ~at_frame_end;

  // Frame start wins over the normal wrap so realignment always lands on 0,0.
  // Before lock the counters never move off 0.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (locked_q) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_q    <= '0;
      row_q    <= '0;
      locked_q <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      locked_q <= locked_q | frame_start;
      resync_q <= resync_d;
    end
  end

  // Position valid for the output register: locked and inside the visible area.
  logic vld_p0;
  logic active_p0;

  assign vld_p0    = locked_q;
  assign active_p0 = vld_p0 && (col_q < ACT_COLS) && (row_q < ACT_ROWS);

  // ---------------------------------------------------------------------------
  // Video alignment: with no lag the video needs one extra register so that it
  // meets the position it belongs to in the output register.
  // ---------------------------------------------------------------------------
  logic [VID_W-1:0] vid_in;
  logic [VID_W-1:0] vid_src;

  assign vid_in = {i_Red_Video, i_Grn_Video, i_Blu_Video};

  generate
    if (VIDEO_LAG == 0) begin : g_lag0
      logic [VID_W-1:0] vid_p0;

      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          vid_p0 <= '0;
        end else begin
          vid_p0 <= vid_in;
        end
      end

      assign vid_src = vid_p0;
    end else begin : g_lag1
      assign vid_src = vid_in;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage p1: sync and video output registers
  // ---------------------------------------------------------------------------
  logic                   hsync_p1;
  logic                   vsync_p1;
  logic                   vld_p1;
  logic [VIDEO_WIDTH-1:0] red_p1;
  logic [VIDEO_WIDTH-1:0] grn_p1;
  logic [VIDEO_WIDTH-1:0] blu_p1;

  // Syncs idle high until the position is valid.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      vld_p1   <= 1'b0;
    end else begin
      hsync_p1 <= vld_p0 ? ~in_range(col_q, HS_FIRST, HS_LAST) : 1'b1;
      vsync_p1 <= vld_p0 ? ~in_range(row_q, VS_FIRST, VS_LAST) : 1'b1;
      vld_p1   <= vld_p0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      red_p1 <= '0;
      grn_p1 <= '0;
      blu_p1 <= '0;
    end else begin
      red_p1 <= blank_video(vid_src[3*VIDEO_WIDTH-1:2*VIDEO_WIDTH], active_p0);
      grn_p1 <= blank_video(vid_src[2*VIDEO_WIDTH-1:VIDEO_WIDTH],   active_p0);
      blu_p1 <= blank_video(vid_src[VIDEO_WIDTH-1:0],               active_p0);
    end
  end

  // vld_p1 tracks the validity of the output word; lock status itself is
  // reported one cycle earlier, straight from the lock flag.
  logic unused_vld_p1;
  assign unused_vld_p1 = vld_p1;

  assign o_HSync     = hsync_p1;
  assign o_VSync     = vsync_p1;
  assign o_Red_Video = red_p1;
  assign o_Grn_Video = grn_p1;
  assign o_Blu_Video = blu_p1;
  assign o_Locked    = locked_q;
  assign o_Resync    = resync_q;

endmodule

// File: doc/vga_sync_porch.md
# vga_sync_porch

Output stage of the VGA video path. It sits directly downstream of the sync generator and test-pattern generator and turns their outputs into the signals that drive the board's VGA connector.
- Inputs: active-area "sync" flags (high while in the visible area) and the registered RGB video that goes with them.
- Function: rebuilds the column and row position from the flags, inserts front and back porches to form active-low HSync/VSync pulses, aligns the video to those pulses and blanks it outside the active area.
- Status: reports lock to the incoming frame and flags any frame start that arrives at an unexpected position.

## Interface
- VIDEO_WIDTH, 3, bits per colour channel
- TOTAL_COLS, 800, pixels per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- FRONT_PORCH_HORZ, 18, columns between end of active area and start of HSync pulse
- BACK_PORCH_HORZ, 50, columns between end of HSync pulse and end of line
- FRONT_PORCH_VERT, 10, rows between end of active area and start of VSync pulse
- BACK_PORCH_VERT, 33, rows between end of VSync pulse and end of frame
- VIDEO_LAG, 1, cycles by which input video lags the input sync flags; legal values 0 or 1

Ports:
- i_Clk, in, 1, system clock
- i_Rst_L, in, 1, asynchronous active-low reset
- i_HSync, in, 1, high while the input column is below ACTIVE_COLS
- i_VSync, in, 1, high while the input row is below ACTIVE_ROWS
- i_Red_Video / i_Grn_Video / i_Blu_Video, in, VIDEO_WIDTH each, input video
- o_HSync, out, 1, active-low horizontal sync
- o_VSync, out, 1, active-low vertical sync
- o_Red_Video / o_Grn_Video / o_Blu_Video, out, VIDEO_WIDTH each, aligned and blanked video
- o_Locked, out, 1, high once the first frame start has been seen
- o_Resync, out, 1, one-cycle pulse when a frame start arrives at an unexpected position

## Operation
- **Frame start:** rising edge of i_VSync, i.e. i_VSync=1 while the registered previous i_VSync=0.
- **Counters:** internal col_q (10 bit) and row_q (10 bit).
  - On a frame start: col_q←0, row_q←0.
  - Otherwise, when locked: col_q increments and wraps from TOTAL_COLS-1 to 0; on that wrap row_q increments and wraps from TOTAL_ROWS-1 to 0.
  - Before lock: both hold 0.
- **Lock:** o_Locked is set on the first frame start and cleared only by reset.
- **Resync:** on a frame start while locked, if the counter was not at (col_q=TOTAL_COLS-1, row_q=TOTAL_ROWS-1), pulse o_Resync for one cycle. The counters still realign to 0,0.
- **Porch / sync generation** (registered from col_q and row_q):
  - o_HSync=0 when ACTIVE_COLS+FRONT_PORCH_HORZ ≤ col_q ≤ TOTAL_COLS-BACK_PORCH_HORZ-1, else 1.
  - o_VSync=0 when ACTIVE_ROWS+FRONT_PORCH_VERT ≤ row_q ≤ TOTAL_ROWS-BACK_PORCH_VERT-1, else 1.
- **Video path:** a (2-VIDEO_LAG)-stage register pipeline; the final stage is the output register.
  - Output is forced to 0 when the position (col_q,row_q) used for the same output cycle has col_q ≥ ACTIVE_COLS or row_q ≥ ACTIVE_ROWS.
- **Unlocked state:** o_HSync=o_VSync=1, all video outputs 0, o_Resync=0.
- **Reset values:** all outputs low except o_HSync=1 and o_VSync=1. Counters, edge register, lock flag and video pipeline are all cleared.
- **Reset mid-frame:** the block returns to unlocked and waits for the next i_VSync rising edge.

## Timing
- Sync latency: input pixel position at cycle t appears on o_HSync/o_VSync at cycle t+2.
  - t+1: counter update.
  - t+2: output register.
- Video latency: o_*_Video at cycle n equals i_*_Video at cycle n-2+VIDEO_LAG, or 0 when blanked. For VIDEO_LAG=1 this is a single register.
- o_Locked rises at the cycle after the frame-start input cycle (t+1).
- o_Resync asserts at t+1 for exactly one cycle.
- The first valid sync outputs appear at t+2 after the frame start.
- A frame start on the same cycle as a counter wrap takes priority over the wrap; the result is always 0,0.
- Porch values are static; parameters must satisfy ACTIVE+FRONT+BACK < TOTAL.

## Test plan
Default bench parameters: TOTAL_COLS=10, TOTAL_ROWS=6, ACTIVE_COLS=8, ACTIVE_ROWS=4, all front porches 1, all back porches 0, VIDEO_LAG=1, with the block driven by the team's sync generator. For these values the pulses fall at col 9 and row 5.

- **Reset:** hold i_Rst_L=0 for 3 cycles. Required: o_HSync=1, o_VSync=1, video 0, o_Locked=0, o_Resync=0.
- **Lock:** release reset with the generator mid-frame. Required: o_Locked stays 0 until the i_VSync rising edge, rises one cycle after it, and o_Resync never pulses.
- **Sync shape:** over two full frames, o_HSync is low for exactly 1 cycle per 10, at col 9. o_VSync is low for exactly 10 cycles per 60, during row 5. Both are offset 2 cycles from the input flags.
- **Video alignment:** drive i_Red_Video = input column index (mod 8). Required: o_Red_Video shows 0..7 on active lines aligned with col 0..7, is 0 at col 8..9, and is 0 on rows 4..5.
- **Resync:** inject an early i_VSync rising edge at col 3, row 2. Required: o_Resync is high for 1 cycle, the counters realign, and the next HSync low occurs 9 columns after the realigned col 0.
- **Reset mid-frame:** pulse i_Rst_L low during row 1. Required: outputs return to reset values immediately (asynchronously), and o_Locked re-asserts after the next frame start.
